// File: rtl/lane_picture_shifter.sv
// rtl/lane_picture_shifter.sv - multi-lane picture shift register with hit/escape scoring
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start, stop       run control pulses (IDLE->RUN, RUN->DRAIN, DRAIN->RUN)
//   clear             synchronous flush of slots, counters and state
//   shift             shift tick: slots move toward slot 0, entry slot may spawn
//   spawn_sel         lane receiving pic_in on a RUN shift (>= LANES: none)
//   pic_in            per-lane picture, lane i at [i*PIC_W +: PIC_W]
//   hit_valid/hit_lane punch attempt on a lane's front slot
//   rd_lane/rd_slot   read address; rd_data is registered (1-cycle latency)
//   occ               occupancy, bit lane*DEPTH+slot
//   hit_ok/hit_miss   registered hit result pulses
//   escape            registered per-lane escape pulse mask
//   score, escapes    saturating counters
//   busy              state is not IDLE
module lane_picture_shifter #(
    parameter int LANES  = 2,
    parameter int DEPTH  = 6,
    parameter int PIC_W  = 160,
    parameter int SEL_W  = 2,
    parameter int SLOT_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   clear,
    input  logic                   shift,
    input  logic [SEL_W-1:0]       spawn_sel,
    input  logic [LANES*PIC_W-1:0] pic_in,
    input  logic                   hit_valid,
    input  logic [SEL_W-1:0]       hit_lane,
    input  logic [SEL_W-1:0]       rd_lane,
    input  logic [SLOT_W-1:0]      rd_slot,
    output logic [PIC_W-1:0]       rd_data,
    output logic [LANES*DEPTH-1:0] occ,
    output logic                   hit_ok,
    output logic                   hit_miss,
    output logic [LANES-1:0]       escape,
    output logic [CNT_W-1:0]       score,
    output logic [CNT_W-1:0]       escapes,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_n;

    logic [PIC_W-1:0]       slots   [LANES][DEPTH];
    logic [PIC_W-1:0]       slots_n [LANES][DEPTH];
    logic [LANES*DEPTH-1:0] occ_n;
    logic [PIC_W-1:0]       rd_n;
    logic                   ok_n, miss_n;
    logic [LANES-1:0]       esc_n;
    logic [LANES-1:0]       hit_kill;
    logic [CNT_W-1:0]       score_n, escapes_n;
    logic                   active;

    assign active = (state != IDLE);
    assign busy   = active;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (stop) state_n = DRAIN;
            // occ is the registered occupancy, so IDLE is reached the cycle
            // after the last monster leaves.
            DRAIN:   if (start) state_n = RUN;
                     else if (occ == '0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (clear) state_n = IDLE;
    end

    always_comb begin
        slots_n   = slots;
        occ_n     = occ;
        rd_n      = '0;
        ok_n      = 1'b0;
        miss_n    = 1'b0;
        esc_n     = '0;
        hit_kill  = '0;
        score_n   = score;
        escapes_n = escapes;

        // Address decode by match rather than indexing so out-of-range
        // addresses naturally read as zero.
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < DEPTH; s++) begin
                if (rd_lane == SEL_W'(l) && rd_slot == SLOT_W'(s)) rd_n = slots[l][s];
            end
        end

        // Hit resolves against the pre-shift front slot.
        if (active && hit_valid) begin
            miss_n = 1'b1;
            for (int l = 0; l < LANES; l++) begin
                if (hit_lane == SEL_W'(l) && occ[l*DEPTH]) begin
                    hit_kill[l] = 1'b1;
                    ok_n        = 1'b1;
                    miss_n      = 1'b0;
                    slots_n[l][0]     = '0;
                    occ_n[l*DEPTH]    = 1'b0;
                end
            end
            if (ok_n && score_n != '1) score_n = score_n + CNT_W'(1);
        end

        if (active && shift) begin
            for (int l = 0; l < LANES; l++) begin
                // A monster killed this cycle cannot also escape.
                esc_n[l] = occ[l*DEPTH] && !hit_kill[l];
                for (int k = 0; k < DEPTH-1; k++) begin
                    slots_n[l][k]      = slots[l][k+1];
                    occ_n[l*DEPTH+k]   = occ[l*DEPTH+k+1];
                end
                if (state == RUN && spawn_sel == SEL_W'(l)) begin
                    slots_n[l][DEPTH-1]        = pic_in[l*PIC_W +: PIC_W];
                    occ_n[l*DEPTH+DEPTH-1]     = 1'b1;
                end else begin
                    slots_n[l][DEPTH-1]        = '0;
                    occ_n[l*DEPTH+DEPTH-1]     = 1'b0;
                end
                if (esc_n[l] && escapes_n != '1) escapes_n = escapes_n + CNT_W'(1);
            end
        end

        if (clear) begin
            for (int l = 0; l < LANES; l++) begin
                for (int s = 0; s < DEPTH; s++) slots_n[l][s] = '0;
            end
            occ_n     = '0;
            ok_n      = 1'b0;
            miss_n    = 1'b0;
            esc_n     = '0;
            score_n   = '0;
            escapes_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            for (int l = 0; l < LANES; l++) begin
                for (int s = 0; s < DEPTH; s++) slots[l][s] <= '0;
            end
            occ      <= '0;
            rd_data  <= '0;
            hit_ok   <= 1'b0;
            hit_miss <= 1'b0;
            escape   <= '0;
            score    <= '0;
            escapes  <= '0;
        end else begin
            state <= state_n;
            for (int l = 0; l < LANES; l++) begin
                for (int s = 0; s < DEPTH; s++) slots[l][s] <= slots_n[l][s];
            end
            occ      <= occ_n;
            rd_data  <= rd_n;
            hit_ok   <= ok_n;
            hit_miss <= miss_n;
            escape   <= esc_n;
            score    <= score_n;
            escapes  <= escapes_n;
        end
    end

endmodule
